alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 32, SHALL set operand and result width.
REQ-002 Parameter FW, default `ALU_FUNCT_WIDTH, SHALL set ALU function-code width; encodings SHALL be those of alu_funct_defines.h.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  2  SHALL carry the per-requester operation-valid flags; bit i belongs to requester i.
REQ-006 req_ready  output  2  SHALL carry the per-requester accept flags; at most one bit set.
REQ-007 req_x, req_y  input  2*N each  SHALL carry the operands; slice [i*N +: N] belongs to requester i.
REQ-008 req_funct  input  2*FW  SHALL carry the ALU function code; slice [i*FW +: FW] belongs to requester i.
REQ-009 rsp_valid  output  2  SHALL be the one-hot result-valid flag for the owning requester.
REQ-010 rsp_ready  input  2  SHALL carry the per-requester result-accept flags.
REQ-011 rsp_z  output  N  SHALL carry the registered ALU result.
REQ-012 rsp_zero, rsp_equal  output  1 each  SHALL carry registered ALU zero (z==0) and equal (x==y) flags.

Function
REQ-013 The block SHALL contain exactly one alu instance shared between the two requesters.
REQ-014 FSM SHALL have two states: IDLE (no result held) and RESP (result held for owner).
REQ-015 In IDLE, grant SHALL go combinationally to the only valid requester or, if both are valid, to the requester named by the priority pointer; req_ready SHALL be the one-hot grant ANDed with req_valid.
REQ-016 In RESP, req_ready SHALL be 2'b00.
REQ-017 On an accept edge (req_valid[i] & req_ready[i]), the ALU output for requester i's operands SHALL be registered into rsp_z/rsp_zero/rsp_equal, owner SHALL become i, and state SHALL go to RESP.
REQ-018 Latency from accept edge to rsp_valid[owner]=1 SHALL be zero further edges, i.e. rsp_valid asserts in the cycle immediately after acceptance.
REQ-019 In RESP, rsp_valid SHALL be one-hot on owner, and rsp_z/rsp_zero/rsp_equal SHALL hold stable until the response handshake.
REQ-020 On a response edge (rsp_valid[owner] & rsp_ready[owner]), state SHALL return to IDLE; rsp_valid SHALL deassert next cycle.
REQ-021 rsp_ready[j] for j != owner SHALL be ignored.
REQ-022 Priority pointer SHALL update on every accept to 1-i (round-robin); it SHALL not change otherwise.
REQ-023 Throughput SHALL be at most one operation per two cycles; there SHALL be no accept in the same cycle as a response handshake.
REQ-024 Unknown funct codes SHALL yield rsp_z=0 (ALU default), rsp_zero=1, with no error signalling.
REQ-025 Requesters are required to hold req_x/req_y/req_funct stable while req_valid is high and unaccepted; the block SHALL not check this.
REQ-026 No combinational path SHALL exist from rsp_ready to req_ready within the same cycle other than through the state register.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE, pointer SHALL be 0, rsp_valid=2'b00, req_ready=2'b00, rsp_z=0, rsp_zero=0, rsp_equal=0, asynchronously.
REQ-028 Reset asserted in RESP SHALL discard the held result immediately, with no response delivered.
REQ-029 After rst_n rises, the first simultaneous request SHALL be granted to requester 0.

Verification
REQ-030 Reset: rst_n=0 with req_valid=2'b11 -> req_ready=00, rsp_valid=00, rsp_z=0; after release, req_ready=01.
REQ-031 Single request: req0 ADD x=5 y=7 -> req_ready=01 in the same cycle; next cycle rsp_valid=01, rsp_z=12, rsp_zero=0, rsp_equal=0.
REQ-032 Contention: req_valid=11 after reset; req0 SUB 9,9; req1 OR 0xF0,0x0F -> req0 granted first (z=0, zero=1, equal=1); after req0's response, req1 granted (z=0xFF), pointer back to 0.
REQ-033 Backpressure: rsp_ready=00 for 3 cycles in RESP -> rsp_valid and rsp_z held stable, req_ready=00 throughout; rsp_ready[1]=1 while owner=0 has no effect.
REQ-034 Signed compare: req1 SLT x=0xFFFFFFFF y=1 -> z=1; SLTU with the same operands -> z=0; SRA x=0x80000000 y=4 -> z=0xF8000000.
REQ-035 Mid-operation reset: pulse rst_n low while in RESP -> rsp_valid=00 without a clock edge; then req_valid=11 -> requester 0 granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the shared-ALU arbiter.
// Also provides the ALU function-code encodings used by the arbiter and its users.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ALU_FUNCT_ADD
`define ALU_FUNCT_ADD  0
`define ALU_FUNCT_SUB  1
`define ALU_FUNCT_AND  2
`define ALU_FUNCT_OR   3
`define ALU_FUNCT_XOR  4
`define ALU_FUNCT_SLL  5
`define ALU_FUNCT_SRL  6
`define ALU_FUNCT_SRA  7
`define ALU_FUNCT_SLT  8
`define ALU_FUNCT_SLTU 9
`endif

interface alu_arbiter_if #(
   parameter int N  = 32,
   parameter int FW = `ALU_FUNCT_WIDTH
);
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [2*N-1:0]  req_x;
   logic [2*N-1:0]  req_y;
   logic [2*FW-1:0] req_funct;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready;
   logic [N-1:0]    rsp_z;
   logic            rsp_zero;
   logic            rsp_equal;

   modport master (
      output req_valid, req_x, req_y, req_funct, rsp_ready,
      input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_equal
   );

   modport slave (
      input  req_valid, req_x, req_y, req_funct, rsp_ready,
      output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_equal
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational ALU; the result is
// registered at acceptance and held until the owning requester takes it.
//
// state | meaning
// IDLE  | no result held; grant offered to a valid requester
// RESP  | result held for owner; no new requests accepted

module alu #(
   parameter int N  = 32,
   parameter int FW = `ALU_FUNCT_WIDTH
) (
   input  logic [N-1:0]  x,
   input  logic [N-1:0]  y,
   input  logic [FW-1:0] funct,
   output logic [N-1:0]  z,
   output logic          zero,
   output logic          equal
);
   localparam int SW = $clog2(N);
   localparam logic [FW-1:0] F_ADD  = FW'(`ALU_FUNCT_ADD);
   localparam logic [FW-1:0] F_SUB  = FW'(`ALU_FUNCT_SUB);
   localparam logic [FW-1:0] F_AND  = FW'(`ALU_FUNCT_AND);
   localparam logic [FW-1:0] F_OR   = FW'(`ALU_FUNCT_OR);
   localparam logic [FW-1:0] F_XOR  = FW'(`ALU_FUNCT_XOR);
   localparam logic [FW-1:0] F_SLL  = FW'(`ALU_FUNCT_SLL);
   localparam logic [FW-1:0] F_SRL  = FW'(`ALU_FUNCT_SRL);
   localparam logic [FW-1:0] F_SRA  = FW'(`ALU_FUNCT_SRA);
   localparam logic [FW-1:0] F_SLT  = FW'(`ALU_FUNCT_SLT);
   localparam logic [FW-1:0] F_SLTU = FW'(`ALU_FUNCT_SLTU);

   logic [SW-1:0] sh;
   assign sh = y[SW-1:0];

   // Unknown codes fall through to zero with no error indication.
   always_comb begin
      z = '0;
      case (funct)
         F_ADD:   z = x + y;
         F_SUB:   z = x - y;
         F_AND:   z = x & y;
         F_OR:    z = x | y;
         F_XOR:   z = x ^ y;
         F_SLL:   z = x << sh;
         F_SRL:   z = x >> sh;
         F_SRA:   z = $signed(x) >>> sh;
         F_SLT:   z = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
         F_SLTU:  z = {{(N-1){1'b0}}, (x < y)};
         default: z = '0;
      endcase
   end

   assign zero  = (z == '0);
   assign equal = (x == y);
endmodule

module alu_arbiter #(
   parameter int N  = 32,
   parameter int FW = `ALU_FUNCT_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic {IDLE, RESP} state_t;

   state_t        state, state_nxt;
   logic          owner, ptr;
   logic [1:0]    grant;
   logic          accept, acc_idx;
   logic [N-1:0]  op_x, op_y, alu_z;
   logic [FW-1:0] op_f;
   logic          alu_zero, alu_equal;
   logic [N-1:0]  z_q;
   logic          zero_q, equal_q;

   // Grant is only offered from IDLE, so rsp_ready reaches req_ready solely via state.
   always_comb begin
      grant     = 2'b00;
      state_nxt = state;
      if (state == IDLE && rst_n) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
         if (grant != 2'b00) state_nxt = RESP;
      end else if (state == RESP && bus.rsp_ready[owner]) begin
         state_nxt = IDLE;
      end
   end

   assign accept  = |grant;
   assign acc_idx = grant[1];
   assign op_x    = acc_idx ? bus.req_x[N +: N]       : bus.req_x[0 +: N];
   assign op_y    = acc_idx ? bus.req_y[N +: N]       : bus.req_y[0 +: N];
   assign op_f    = acc_idx ? bus.req_funct[FW +: FW] : bus.req_funct[0 +: FW];

   alu #(.N(N), .FW(FW)) u_alu (
      .x     (op_x),
      .y     (op_y),
      .funct (op_f),
      .z     (alu_z),
      .zero  (alu_zero),
      .equal (alu_equal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= 1'b0;
         ptr     <= 1'b0;
         z_q     <= '0;
         zero_q  <= 1'b0;
         equal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner   <= acc_idx;
            ptr     <= ~acc_idx;
            z_q     <= alu_z;
            zero_q  <= alu_zero;
            equal_q <= alu_equal;
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_z     = z_q;
   assign bus.rsp_zero  = zero_q;
   assign bus.rsp_equal = equal_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the two-requester arbitration and ALU.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ALU_FUNCT_ADD
`define ALU_FUNCT_ADD  0
`define ALU_FUNCT_SUB  1
`define ALU_FUNCT_AND  2
`define ALU_FUNCT_OR   3
`define ALU_FUNCT_XOR  4
`define ALU_FUNCT_SLL  5
`define ALU_FUNCT_SRL  6
`define ALU_FUNCT_SRA  7
`define ALU_FUNCT_SLT  8
`define ALU_FUNCT_SLTU 9
`endif

module tb_alu_arbiter;
   localparam int N  = 32;
   localparam int FW = `ALU_FUNCT_WIDTH;
   localparam int F_ADD = `ALU_FUNCT_ADD,  F_SUB = `ALU_FUNCT_SUB, F_AND = `ALU_FUNCT_AND;
   localparam int F_OR  = `ALU_FUNCT_OR,   F_XOR = `ALU_FUNCT_XOR, F_SLL = `ALU_FUNCT_SLL;
   localparam int F_SRL = `ALU_FUNCT_SRL,  F_SRA = `ALU_FUNCT_SRA, F_SLT = `ALU_FUNCT_SLT;
   localparam int F_SLTU = `ALU_FUNCT_SLTU;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.N(N), .FW(FW)) bus ();
   alu_arbiter #(.N(N), .FW(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int vectors = 0;
   int errors  = 0;

   function automatic logic [N-1:0] ref_alu(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input int f);
      int sh;
      logic [N-1:0] r;
      sh = int'(y[4:0]);
      r  = '0;
      if (f == F_ADD)       r = x + y;
      else if (f == F_SUB)  r = x - y;
      else if (f == F_AND)  r = x & y;
      else if (f == F_OR)   r = x | y;
      else if (f == F_XOR)  r = x ^ y;
      else if (f == F_SLL)  r = x << sh;
      else if (f == F_SRL)  r = x >> sh;
      else if (f == F_SRA) begin
         r = x >> sh;
         if (x[N-1]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      else if (f == F_SLT)  r = (x[N-1] != y[N-1]) ? {31'd0, x[N-1]} : {31'd0, x < y};
      else if (f == F_SLTU) r = {31'd0, x < y};
      return r;
   endfunction

   task automatic set_req(input int i, input logic [N-1:0] x, input logic [N-1:0] y, input int f);
      bus.req_x[i*N +: N]       = x;
      bus.req_y[i*N +: N]       = y;
      bus.req_funct[i*FW +: FW] = FW'(f);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_req(0, 32'd1, 32'd2, F_ADD);
      set_req(1, 32'd3, 32'd4, F_ADD);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b00;
      tick(); tick();
      vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
      vectors++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
      vectors++; if (bus.rsp_z !== 32'd0) begin errors++; $display("FAIL reset_rsp_z got %h exp 0", bus.rsp_z); end
      vectors++; if ({bus.rsp_zero, bus.rsp_equal} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.rsp_zero, bus.rsp_equal}); end
      rst_n = 1'b1;
      #1;
      vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL release_req_ready got %b exp 01", bus.req_ready); end
      bus.req_valid = 2'b00;
      tick();
   endtask

   task automatic test_single();
      set_req(0, 32'd5, 32'd7, F_ADD);
      bus.req_valid = 2'b01;
      #1;
      vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      #1;
      vectors++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", bus.rsp_valid); end
      vectors++; if (bus.rsp_z !== 32'd12) begin errors++; $display("FAIL single_rsp_z got %0d exp 12", bus.rsp_z); end
      vectors++; if ({bus.rsp_zero, bus.rsp_equal} !== 2'b00) begin errors++; $display("FAIL single_flags got %b exp 00", {bus.rsp_zero, bus.rsp_equal}); end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
      vectors++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_drop got %b exp 00", bus.rsp_valid); end
   endtask

   task automatic test_contention();
      do_reset();
      set_req(0, 32'd9, 32'd9, F_SUB);
      set_req(1, 32'hF0, 32'h0F, F_OR);
      bus.req_valid = 2'b11;
      #1;
      vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b10;
      #1;
      vectors++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL cont_rsp0_valid got %b exp 01", bus.rsp_valid); end
      vectors++; if ({bus.rsp_z, bus.rsp_zero, bus.rsp_equal} !== {32'd0, 2'b11}) begin errors++; $display("FAIL cont_rsp0 got z=%h zero=%b eq=%b exp z=0 zero=1 eq=1", bus.rsp_z, bus.rsp_zero, bus.rsp_equal); end
      vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_busy_ready got %b exp 00", bus.req_ready); end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
      vectors++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL cont_second_grant got %b exp 10", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      #1;
      vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_z !== 32'hFF) begin errors++; $display("FAIL cont_rsp1 got valid=%b z=%h exp valid=10 z=ff", bus.rsp_valid, bus.rsp_z); end
      bus.rsp_ready = 2'b10;
      tick();
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b11;
      #1;
      vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL cont_ptr_back got %b exp 01", bus.req_ready); end
      bus.req_valid = 2'b00;
      tick();
   endtask

   task automatic test_backpressure();
      logic [N-1:0] exp_z;
      exp_z = 32'h1234 ^ 32'h00FF;
      set_req(0, 32'h1234, 32'h00FF, F_XOR);
      set_req(1, 32'd1, 32'd1, F_ADD);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++; if (bus.rsp_valid !== 2'b01 || bus.rsp_z !== exp_z || bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL backpressure_hold cyc%0d got valid=%b z=%h ready=%b exp valid=01 z=%h ready=00", c, bus.rsp_valid, bus.rsp_z, bus.req_ready, exp_z);
         end
         tick();
      end
      bus.rsp_ready = 2'b01;
      bus.req_valid = 2'b00;
      tick();
      bus.rsp_ready = 2'b00;
      vectors++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL backpressure_release got %b exp 00", bus.rsp_valid); end
   endtask

   task automatic test_signed();
      logic [N-1:0] tx [3];
      logic [N-1:0] ty [3];
      logic [N-1:0] tz [3];
      int tf [3];
      tx = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      ty = '{32'd1, 32'd1, 32'd4};
      tf = '{F_SLT, F_SLTU, F_SRA};
      tz = '{32'd1, 32'd0, 32'hF800_0000};
      for (int k = 0; k < 3; k++) begin
         set_req(1, tx[k], ty[k], tf[k]);
         bus.req_valid = 2'b10;
         #1;
         vectors++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL signed_grant%0d got %b exp 10", k, bus.req_ready); end
         tick();
         bus.req_valid = 2'b00;
         vectors++; if (bus.rsp_valid !== 2'b10 || bus.rsp_z !== tz[k]) begin errors++; $display("FAIL signed_op%0d got valid=%b z=%h exp valid=10 z=%h", k, bus.rsp_valid, bus.rsp_z, tz[k]); end
         bus.rsp_ready = 2'b10;
         tick();
         bus.rsp_ready = 2'b00;
      end
   endtask

   task automatic test_midreset();
      set_req(0, 32'd3, 32'd4, F_ADD);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      vectors++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL midreset_pre got %b exp 01", bus.rsp_valid); end
      rst_n = 1'b0;
      #1;
      vectors++; if (bus.rsp_valid !== 2'b00 || bus.rsp_z !== 32'd0) begin errors++; $display("FAIL midreset_async got valid=%b z=%h exp 00 0", bus.rsp_valid, bus.rsp_z); end
      rst_n = 1'b1;
      #1;
      bus.req_valid = 2'b11;
      #1;
      vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midreset_grant got %b exp 01", bus.req_ready); end
      bus.req_valid = 2'b00;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] px [2];
      logic [N-1:0] py [2];
      int           pf [2];
      bit           pend [2];
      bit           m_busy, m_zero, m_eq;
      int           m_owner, m_ptr, i;
      logic [N-1:0] m_z;
      logic [1:0]   exp_ready, exp_rv;
      do_reset();
      pend = '{0, 0};
      m_busy = 0; m_owner = 0; m_ptr = 0; m_z = '0; m_zero = 0; m_eq = 0;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1;
               px[r] = $urandom;
               py[r] = ($urandom_range(0, 3) == 0) ? px[r] : $urandom;
               pf[r] = $urandom_range(0, 15);
            end
            if (pend[r]) set_req(r, px[r], py[r], pf[r]);
         end
         bus.req_valid = {pend[1], pend[0]};
         bus.rsp_ready = 2'($urandom_range(0, 3));
         #1;
         exp_ready = 2'b00;
         if (!m_busy) begin
            if (pend[0] && pend[1]) exp_ready = (m_ptr == 0) ? 2'b01 : 2'b10;
            else if (pend[0])       exp_ready = 2'b01;
            else if (pend[1])       exp_ready = 2'b10;
         end
         exp_rv = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
         vectors++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_req_ready cyc%0d got %b exp %b", c, bus.req_ready, exp_ready); end
         vectors++; if (bus.rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid cyc%0d got %b exp %b", c, bus.rsp_valid, exp_rv); end
         if (m_busy) begin
            vectors++; if ({bus.rsp_z, bus.rsp_zero, bus.rsp_equal} !== {m_z, m_zero, m_eq}) begin
               errors++; $display("FAIL rand_result cyc%0d got z=%h zero=%b eq=%b exp z=%h zero=%b eq=%b", c, bus.rsp_z, bus.rsp_zero, bus.rsp_equal, m_z, m_zero, m_eq);
            end
         end
         if (exp_ready != 2'b00) begin
            i = exp_ready[1] ? 1 : 0;
            m_z = ref_alu(px[i], py[i], pf[i]);
            m_zero = (m_z == 0);
            m_eq = (px[i] == py[i]);
            m_owner = i;
            m_ptr = 1 - i;
            m_busy = 1;
            pend[i] = 0;
         end else if (m_busy && bus.rsp_ready[m_owner]) begin
            m_busy = 0;
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
   endtask

   initial begin
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.req_funct = '0;
      #1;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_signed();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
